// File: rtl/rule_cfg_loader.sv
// Rule-configuration master: queues host commands, issues paced single-cycle
// rule writes and optionally reads each entry back to compare it under a mask.
module rule_cfg_loader #(
  parameter int CMD_DEPTH  = 8,
  parameter int WR_GAP     = 1,
  parameter int RD_TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic        i_cmd_verify,
  input  logic [31:0] i_cmd_addr,
  input  logic [31:0] i_cmd_wdata,
  input  logic [31:0] i_cmd_mask,
  output logic        o_rule_wren,
  output logic        o_rule_rden,
  output logic [31:0] o_rule_addr,
  output logic [31:0] o_rule_wdata,
  input  logic        i_rule_rdata_valid,
  input  logic [31:0] i_rule_rdata,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [1:0]  o_err_code,
  output logic [31:0] o_err_addr,
  output logic [15:0] o_wr_cnt,
  output logic [7:0]  o_err_cnt,
  input  logic        i_err_clr
);

  localparam int AW = $clog2(CMD_DEPTH);
  localparam int GW = (WR_GAP < 2) ? 1 : $clog2(WR_GAP);
  localparam int TW = $clog2(RD_TIMEOUT + 1);
  localparam logic [AW:0] FULL_CNT = CMD_DEPTH[AW:0];

  typedef struct packed {
    logic        verify;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mask;
  } cmd_t;

  typedef enum logic [2:0] {IDLE, WRITE, GAP, READ, WAIT_RD} state_t;

  cmd_t            mem_q [CMD_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     cnt_q, cnt_d;
  cmd_t            hold_q, hold_d;
  state_t          state_q, state_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [TW-1:0]   tmr_q, tmr_d;

  logic            wren_q, wren_d, rden_q, rden_d;
  logic [31:0]     addr_q, addr_d, wdata_q, wdata_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic            err_q, err_d;
  logic [1:0]      err_code_q, err_code_d;
  logic [31:0]     err_addr_q, err_addr_d;
  logic [15:0]     wr_cnt_q, wr_cnt_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic            cmd_ready_q, cmd_ready_d;

  logic            push, pop;
  logic [1:0]      ev_code;

  always_comb begin
    push     = i_cmd_valid && cmd_ready_q;
    pop      = (state_q == IDLE) && (cnt_q != '0);
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    hold_d   = pop ? mem_q[rd_ptr_q] : hold_q;

    state_d = state_q;
    gap_d   = gap_q;
    tmr_d   = tmr_q;
    ev_code = 2'b00;
    case (state_q)
      IDLE:    if (pop) state_d = WRITE;
      WRITE: begin
        gap_d = '0;
        if (WR_GAP > 0) state_d = GAP;
        else            state_d = hold_q.verify ? READ : IDLE;
      end
      GAP: begin
        if (int'(gap_q) >= WR_GAP - 1) state_d = hold_q.verify ? READ : IDLE;
        else                           gap_d   = gap_q + 1'b1;
      end
      READ: begin
        tmr_d   = '0;
        state_d = WAIT_RD;
      end
      WAIT_RD: begin
        tmr_d = tmr_q + 1'b1;
        // readback arriving on the last timeout cycle still counts
        if (i_rule_rdata_valid) begin
          if ((i_rule_rdata & hold_q.mask) != (hold_q.wdata & hold_q.mask)) ev_code = 2'b01;
          state_d = IDLE;
        end else if (int'(tmr_q) >= RD_TIMEOUT - 1) begin
          ev_code = 2'b10;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    wren_d   = (state_q == WRITE);
    rden_d   = (state_q == READ);
    addr_d   = (wren_d || rden_d) ? hold_q.addr  : addr_q;
    wdata_d  = (wren_d || rden_d) ? hold_q.wdata : wdata_q;
    wr_cnt_d = (wren_d && wr_cnt_q != 16'hFFFF) ? wr_cnt_q + 16'd1 : wr_cnt_q;

    err_d      = err_q;
    err_code_d = err_code_q;
    err_addr_d = err_addr_q;
    err_cnt_d  = err_cnt_q;
    if (ev_code != 2'b00) begin
      err_d      = 1'b1;
      err_code_d = ev_code;
      err_addr_d = hold_q.addr;
      if (i_err_clr)                err_cnt_d = 8'd1;
      else if (err_cnt_q != 8'hFF)  err_cnt_d = err_cnt_q + 8'd1;
    end else if (i_err_clr) begin
      err_d      = 1'b0;
      err_code_d = 2'b00;
      err_addr_d = '0;
      err_cnt_d  = '0;
    end

    done_d = (state_d == IDLE) && (cnt_q == '0) && !push &&
             (state_q == WRITE || state_q == GAP || state_q == WAIT_RD);
    busy_d      = (cnt_d != '0) || (state_d != IDLE);
    cmd_ready_d = (cnt_d != FULL_CNT);
  end

  // Storage is not reset; the pointers and count define validity.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= {i_cmd_verify, i_cmd_addr, i_cmd_wdata, i_cmd_mask};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
      state_q     <= IDLE;
      gap_q       <= '0;
      tmr_q       <= '0;
      wren_q      <= 1'b0;
      rden_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
      err_addr_q  <= '0;
      wr_cnt_q    <= '0;
      err_cnt_q   <= '0;
      cmd_ready_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      state_q     <= state_d;
      gap_q       <= gap_d;
      tmr_q       <= tmr_d;
      wren_q      <= wren_d;
      rden_q      <= rden_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      err_addr_q  <= err_addr_d;
      wr_cnt_q    <= wr_cnt_d;
      err_cnt_q   <= err_cnt_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign o_cmd_ready  = cmd_ready_q;
  assign o_rule_wren  = wren_q;
  assign o_rule_rden  = rden_q;
  assign o_rule_addr  = addr_q;
  assign o_rule_wdata = wdata_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_err        = err_q;
  assign o_err_code   = err_code_q;
  assign o_err_addr   = err_addr_q;
  assign o_wr_cnt     = wr_cnt_q;
  assign o_err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_rule_cfg_loader.sv
// Scoreboard bench for rule_cfg_loader: expected writes/reads are queued on
// command accept and popped when the strobes appear.
module tb_rule_cfg_loader;
  localparam int DEPTH = 8;
  localparam int GAPC  = 1;
  localparam int TMO   = 16;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_cmd_valid = 1'b0, i_cmd_verify = 1'b0;
  logic [31:0] i_cmd_addr = '0, i_cmd_wdata = '0, i_cmd_mask = '0;
  logic        i_rule_rdata_valid;
  logic [31:0] i_rule_rdata;
  logic        clr_main = 1'b0, clr_resp = 1'b0;
  logic        i_err_clr;
  logic        o_cmd_ready, o_rule_wren, o_rule_rden, o_busy, o_done, o_err;
  logic [31:0] o_rule_addr, o_rule_wdata, o_err_addr;
  logic [1:0]  o_err_code;
  logic [15:0] o_wr_cnt;
  logic [7:0]  o_err_cnt;

  assign i_err_clr = clr_main | clr_resp;

  always #5 clk = ~clk;

  rule_cfg_loader #(.CMD_DEPTH(DEPTH), .WR_GAP(GAPC), .RD_TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_verify(i_cmd_verify),
    .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata), .i_cmd_mask(i_cmd_mask),
    .o_rule_wren(o_rule_wren), .o_rule_rden(o_rule_rden),
    .o_rule_addr(o_rule_addr), .o_rule_wdata(o_rule_wdata),
    .i_rule_rdata_valid(i_rule_rdata_valid), .i_rule_rdata(i_rule_rdata),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_err_code(o_err_code),
    .o_err_addr(o_err_addr), .o_wr_cnt(o_wr_cnt), .o_err_cnt(o_err_cnt),
    .i_err_clr(i_err_clr)
  );

  typedef struct {logic [31:0] a; logic [31:0] d;} xact_t;
  xact_t sb_wr[$];
  xact_t sb_rd[$];

  int n_chk = 0, n_fail = 0;
  int cyc = 0, acc_cyc = 0;
  int wr_n = 0, rd_n = 0, done_n = 0;
  int last_wr_cyc = 0, last_rd_cyc = 0, err_rise_cyc = 0;
  bit err_prev = 1'b0, space_en = 1'b0, space_have = 1'b0;
  bit resp_en = 1'b0, resp_clr = 1'b0;
  int resp_delay = 3;
  logic [31:0] resp_data = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // monitor: pops the scoreboards on each strobe
  initial forever begin
    xact_t x;
    @(negedge clk);
    if (o_rule_wren) begin
      wr_n++;
      chk("wr_expected", sb_wr.size() != 0, 1);
      if (sb_wr.size() != 0) begin
        x = sb_wr.pop_front();
        chk("wr_addr", o_rule_addr, x.a);
        chk("wr_data", o_rule_wdata, x.d);
      end
      if (space_en) begin
        if (space_have) chk("wr_spacing", cyc - last_wr_cyc, 2 + GAPC);
        space_have = 1'b1;
      end
      last_wr_cyc = cyc;
    end
    if (o_rule_rden) begin
      rd_n++;
      last_rd_cyc = cyc;
      chk("rd_expected", sb_rd.size() != 0, 1);
      if (sb_rd.size() != 0) begin
        x = sb_rd.pop_front();
        chk("rd_addr", o_rule_addr, x.a);
        chk("rd_wdata_held", o_rule_wdata, x.d);
      end
    end
    if (o_done) done_n++;
    if (o_err && !err_prev) err_rise_cyc = cyc;
    err_prev = o_err;
  end

  // readback responder: answers resp_delay cycles after rden
  initial begin
    i_rule_rdata_valid = 1'b0;
    i_rule_rdata = '0;
    forever begin
      @(negedge clk);
      if (o_rule_rden && resp_en) begin
        repeat (resp_delay) @(negedge clk);
        i_rule_rdata_valid = 1'b1;
        i_rule_rdata = resp_data;
        clr_resp = resp_clr;
        @(negedge clk);
        i_rule_rdata_valid = 1'b0;
        clr_resp = 1'b0;
      end
    end
  end

  task automatic push_cmd(input bit v, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] m);
    int n = 0;
    i_cmd_verify = v; i_cmd_addr = a; i_cmd_wdata = d; i_cmd_mask = m;
    i_cmd_valid = 1'b1;
    while (!o_cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready_wait", o_cmd_ready, 1);
    @(posedge clk);
    sb_wr.push_back('{a, d});
    if (v) sb_rd.push_back('{a, d});
    @(negedge clk);
    acc_cyc = cyc;
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while (o_busy && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", o_busy, 0);
    @(negedge clk);
  endtask

  task automatic wait_rd(input int target);
    int n = 0;
    while (rd_n < target && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rden_wait", rd_n >= target, 1);
  endtask

  task automatic pulse_clr();
    clr_main = 1'b1;
    @(negedge clk);
    clr_main = 1'b0;
  endtask

  initial begin
    int a1, w0, r0, d0;
    // reset
    repeat (3) @(negedge clk);
    chk("rst_ready", o_cmd_ready, 0);
    chk("rst_wren", o_rule_wren, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_wrcnt", o_wr_cnt, 0);
    chk("rst_err", o_err, 0);
    i_rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", o_cmd_ready, 1);

    // plain write: latency, counter, done
    push_cmd(0, 32'h0000_0400, 32'h7, 32'h0);
    a1 = acc_cyc;
    i_cmd_valid = 1'b0;
    wait_idle(50);
    chk("t1_latency", last_wr_cyc - a1, 2);
    chk("t1_wrcnt", o_wr_cnt, 1);
    chk("t1_done", done_n, 1);
    chk("t1_err", o_err, 0);

    // masked verify: pass, then mismatch
    resp_en = 1'b1; resp_delay = 3; resp_data = 32'hFFFF_0106;
    push_cmd(1, 32'h0000_0301, 32'h0001_0106, 32'h0001_1F3F);
    i_cmd_valid = 1'b0;
    wait_idle(100);
    chk("t2_masked_err", o_err, 0);
    chk("t2_masked_cnt", o_err_cnt, 0);
    resp_data = 32'h0000_0106;
    push_cmd(1, 32'h0000_0301, 32'h0001_0106, 32'h0001_1F3F);
    i_cmd_valid = 1'b0;
    wait_idle(100);
    chk("t2_err", o_err, 1);
    chk("t2_code", o_err_code, 2'b01);
    chk("t2_addr", o_err_addr, 32'h0000_0301);
    chk("t2_cnt", o_err_cnt, 1);
    chk("t2_wrcnt", o_wr_cnt, 3);
    chk("t2_rd_sb", sb_rd.size(), 0);

    // error coinciding with clear, then clear alone
    resp_clr = 1'b1;
    push_cmd(1, 32'h0000_0301, 32'h0001_0106, 32'h0001_1F3F);
    i_cmd_valid = 1'b0;
    wait_idle(100);
    resp_clr = 1'b0;
    chk("t5_err", o_err, 1);
    chk("t5_cnt", o_err_cnt, 1);
    pulse_clr();
    chk("t5_clr_err", o_err, 0);
    chk("t5_clr_code", o_err_code, 0);
    chk("t5_clr_addr", o_err_addr, 0);
    chk("t5_clr_cnt", o_err_cnt, 0);

    // timeout, next queued command still proceeds
    resp_en = 1'b0;
    push_cmd(1, 32'h0000_0500, 32'h55, 32'hFFFF_FFFF);
    push_cmd(0, 32'h0000_0600, 32'h66, 32'h0);
    i_cmd_valid = 1'b0;
    wait_idle(200);
    chk("t3_to_latency", err_rise_cyc - last_rd_cyc, TMO);
    chk("t3_code", o_err_code, 2'b10);
    chk("t3_addr", o_err_addr, 32'h0000_0500);
    chk("t3_cnt", o_err_cnt, 1);
    chk("t3_wr_sb", sb_wr.size(), 0);
    chk("t3_wrcnt", o_wr_cnt, 6);
    // readback on the final timeout cycle wins
    pulse_clr();
    resp_en = 1'b1; resp_delay = TMO - 1; resp_data = 32'h77;
    push_cmd(1, 32'h0000_0510, 32'h77, 32'hFFFF_FFFF);
    i_cmd_valid = 1'b0;
    wait_idle(200);
    chk("t3_last_err", o_err, 0);
    chk("t3_last_cnt", o_err_cnt, 0);

    // reset while waiting for readback with entries queued
    resp_delay = 10; resp_data = 32'h0;
    push_cmd(1, 32'h0000_0800, 32'h88, 32'hFFFF_FFFF);
    for (int i = 1; i <= 3; i++) push_cmd(0, 32'h0000_0800 + i, 32'h80 + i, 32'h0);
    i_cmd_valid = 1'b0;
    wait_rd(rd_n + 1);
    i_rst = 1'b1;
    @(negedge clk);
    chk("t6_wren", o_rule_wren, 0);
    chk("t6_rden", o_rule_rden, 0);
    chk("t6_addr", o_rule_addr, 0);
    chk("t6_wdata", o_rule_wdata, 0);
    chk("t6_busy", o_busy, 0);
    chk("t6_ready", o_cmd_ready, 0);
    chk("t6_wrcnt", o_wr_cnt, 0);
    chk("t6_err", o_err, 0);
    sb_wr.delete();
    sb_rd.delete();
    w0 = wr_n; r0 = rd_n;
    i_rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("t6_no_wren", wr_n - w0, 0);
    chk("t6_no_rden", rd_n - r0, 0);
    chk("t6_late_valid_err", o_err, 0);
    chk("t6_idle_busy", o_busy, 0);
    chk("t6_idle_ready", o_cmd_ready, 1);

    // FIFO fill while stalled on a timing-out readback
    resp_en = 1'b0;
    d0 = done_n;
    push_cmd(1, 32'h0000_0700, 32'h70, 32'hFFFF_FFFF);
    i_cmd_valid = 1'b0;
    wait_rd(rd_n + 1);
    space_en = 1'b1; space_have = 1'b0;
    for (int i = 0; i < 9; i++) begin
      push_cmd(0, 32'h0000_0900 + i, 32'hA0 + i, 32'h0);
      if (i == DEPTH - 1) chk("t4_full_ready", o_cmd_ready, 0);
    end
    i_cmd_valid = 1'b0;
    wait_idle(300);
    space_en = 1'b0;
    chk("t4_wrcnt", o_wr_cnt, 10);
    chk("t4_done", done_n - d0, 1);
    chk("t4_code", o_err_code, 2'b10);
    chk("t4_addr", o_err_addr, 32'h0000_0700);
    chk("t4_wr_sb", sb_wr.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
    $fatal(1);
  end

endmodule
